updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
Parametrised successor to the single-width enable counter: a modulo-N up/down counter with synchronous load, clear, and a selectable wrap or saturate mode. It emits registered terminal-count, wrap-event and sticky-overflow outputs. It serves as the generic count/timer primitive for rate dividers, FIFO pointers and timeout logic. The next-state kernel is purely combinational; all state sits in one async-reset register bank.

Parameters:
WIDTH, 8, bit width of count and load_value; 1..32.
MODULUS, 256, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
RESET_VALUE, 0, count value after reset; must be < MODULUS.

Ports:
clock_reset  in   2      bundled clock/reset: bit 0 = clock (posedge), bit 1 = reset, asynchronous, active-high
clear        in   1      synchronous clear to 0 and clear sticky flag
load         in   1      synchronous load of load_value
load_value   in   WIDTH  value to load
enable       in   1      count step enable
up           in   1      1 = increment, 0 = decrement
count        out  WIDTH  current count, registered
terminal     out  1      registered; 1 when count == MODULUS-1 (up=1) or count == 0 (up=0), evaluated on the next-state count and the current up
wrapped      out  1      registered one-cycle pulse: a wrap occurred, or a saturate clip was attempted
overflow     out  1      sticky; set on any wrapped event, cleared by clear or reset

Behaviour:
- Reset (clock_reset[1] high): asynchronous, independent of clock.
  - count = RESET_VALUE, terminal = 0, wrapped = 0, overflow = 0.
  - Held while reset is high; the first update occurs on the first posedge after deassertion.
  - Register initial values match the reset values.
- Per-posedge priority: clear > load > enable > hold.
- clear: count <= 0, overflow <= 0, wrapped <= 0. load, enable and up are ignored.
- load (clear = 0):
  - count <= load_value when load_value < MODULUS; otherwise count <= MODULUS-1 (clamp).
  - A clamped load does not pulse wrapped. The overflow flag is unchanged.
- enable, up = 1:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1: SATURATE=0 gives 0; SATURATE=1 holds. Either case sets wrapped and overflow.
- enable, up = 0:
  - count > 0: count-1.
  - count == 0: SATURATE=0 gives MODULUS-1; SATURATE=1 holds 0. Either case sets wrapped and overflow.
- Hold (no clear/load/enable): count unchanged, wrapped <= 0, overflow unchanged.
- Latency: all outputs update exactly one clock after the causing inputs; there is no combinational input-to-output path.
- Arithmetic:
  - Computed at WIDTH+1 bits, then truncated to WIDTH.
  - MODULUS == 2**WIDTH must wrap correctly with no out-of-range compare.
- Reset mid-count: count returns to RESET_VALUE immediately and any pending wrapped pulse is dropped.
- Elaboration errors: MODULUS out of range, RESET_VALUE >= MODULUS, or WIDTH out of range.

Decomposition:
- Shared package: counter mode constants (MODE_WRAP = 0, MODE_SATURATE = 1) and the updown_counter_state record typedef {count, terminal, wrapped, overflow}.
- One sub-module, async_reg: a WIDTH-parametrised posedge register with async active-high reset to a parameter value, fed from clock_reset. Top-level contents:
  - combinational next-state kernel;
  - one async_reg instance for the packed state;
  - output unpacking.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0, up=1, enable=1 for 12 clocks from reset -> count 1..9,0,1,2. wrapped is high only on the clock count becomes 0. overflow goes 1 and stays. terminal is high while count==9.
2. Same config, up=0 from count=0 -> count 9,8,...; wrapped pulses on the 0->9 step.
3. SATURATE=1, MODULUS=10, count at 9, up=1, enable=1 for 3 clocks -> count holds 9, wrapped high each clock, overflow=1. Then up=0 gives 8.
4. load=1, load_value=4'hC with MODULUS=10 -> count=9 (clamped), no wrapped pulse. load=1, load_value=5 together with enable=1 -> count=5 (load beats enable). clear=1 with load=1 -> count=0, overflow=0.
5. Assert reset asynchronously between edges at count=6, RESET_VALUE=3 -> count=3 before the next posedge and all flags 0. count remains 3 until the first posedge after deassertion.
6. WIDTH=4, MODULUS=16, up=1 from count 15 -> count 0, wrapped pulse; down from 0 -> 15 (full-range wrap check).

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: mode constants and the
// state record held in the counter's register bank.
package updown_counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    // Widest count the counter supports; narrower instances zero-extend into it.
    localparam int MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] count;
        logic                 terminal;
        logic                 wrapped;
        logic                 overflow;
    } updown_counter_state;

endpackage

// File: rtl/updown_counter_async_reg.sv
// Posedge register with asynchronous active-high reset to a parameter value,
// clocked from the bundled {reset, clock} pair.
module async_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [1:0]       clock_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic clock;
    logic reset;

    assign clock = clock_reset[0];
    assign reset = clock_reset[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Modulo-N up/down counter with clear, clamped load and wrap/saturate mode.
// A combinational next-state kernel feeds a single async-reset register bank.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int     WIDTH       = 8,
    parameter longint MODULUS     = 256,
    parameter int     SATURATE    = MODE_WRAP,
    parameter longint RESET_VALUE = 0
) (
    input  logic [1:0]       clock_reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrapped,
    output logic             overflow
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
        $error("updown_counter: RESET_VALUE must be below MODULUS");
    end

    localparam int               REG_W     = WIDTH + 3;
    localparam logic [WIDTH:0]   TOP_EXT   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP       = WIDTH'(MODULUS - 1);
    localparam logic [REG_W-1:0] REG_RESET = {WIDTH'(RESET_VALUE), 3'b000};
    localparam logic             SAT       = (SATURATE == MODE_SATURATE);

    updown_counter_state state_q;
    updown_counter_state state_d;
    logic [REG_W-1:0]    reg_d;
    logic [REG_W-1:0]    reg_q;
    logic [WIDTH:0]      cnt_ext;
    logic [WIDTH:0]      inc_ext;
    logic [WIDTH:0]      dec_ext;
    logic [WIDTH-1:0]    nxt_count;
    logic                at_top;
    logic                at_zero;
    logic                unused_bits;

    // Steps are formed one bit wider so the top-of-range test never overflows,
    // which keeps MODULUS == 2**WIDTH correct.
    assign cnt_ext = {1'b0, state_q.count[WIDTH-1:0]};
    assign inc_ext = cnt_ext + 1'b1;
    assign dec_ext = cnt_ext - 1'b1;
    assign at_top  = (cnt_ext == TOP_EXT);
    assign at_zero = (cnt_ext == '0);

    always_comb begin
        nxt_count        = state_q.count[WIDTH-1:0];
        state_d          = '0;
        state_d.overflow = state_q.overflow;
        if (clear) begin
            nxt_count        = '0;
            state_d.overflow = 1'b0;
        end else if (load) begin
            nxt_count = ({1'b0, load_value} > TOP_EXT) ? TOP : load_value;
        end else if (enable) begin
            if (up) begin
                if (at_top) begin
                    nxt_count        = SAT ? TOP : '0;
                    state_d.wrapped  = 1'b1;
                    state_d.overflow = 1'b1;
                end else begin
                    nxt_count = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    nxt_count        = SAT ? '0 : TOP;
                    state_d.wrapped  = 1'b1;
                    state_d.overflow = 1'b1;
                end else begin
                    nxt_count = dec_ext[WIDTH-1:0];
                end
            end
        end
        state_d.count    = MAX_WIDTH'(nxt_count);
        state_d.terminal = up ? (nxt_count == TOP) : (nxt_count == '0);
    end

    assign reg_d = {state_d.count[WIDTH-1:0], state_d.terminal,
                    state_d.wrapped, state_d.overflow};

    async_reg #(
        .WIDTH       (REG_W),
        .RESET_VALUE (REG_RESET)
    ) u_state_reg (
        .clock_reset (clock_reset),
        .d           (reg_d),
        .q           (reg_q)
    );

    assign state_q.count    = MAX_WIDTH'(reg_q[REG_W-1:3]);
    assign state_q.terminal = reg_q[2];
    assign state_q.wrapped  = reg_q[1];
    assign state_q.overflow = reg_q[0];

    assign count    = state_q.count[WIDTH-1:0];
    assign terminal = state_q.terminal;
    assign wrapped  = state_q.wrapped;
    assign overflow = state_q.overflow;

    // Carry bits and zero-extension padding never influence the outputs.
    if (WIDTH < MAX_WIDTH) begin : g_pad
        assign unused_bits = ^{inc_ext[WIDTH], dec_ext[WIDTH],
                               state_q.count[MAX_WIDTH-1:WIDTH],
                               state_d.count[MAX_WIDTH-1:WIDTH]};
    end else begin : g_nopad
        assign unused_bits = ^{inc_ext[WIDTH], dec_ext[WIDTH]};
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: wrap, saturate and full-range instances
// driven from one linear sequence with hand-computed expectations.
module tb_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // u_w: WIDTH=4 MODULUS=10 wrap; u_s: MODULUS=10 saturate, RESET_VALUE=3; u_f: MODULUS=16 wrap
    logic       rst_w, clr_w, ld_w, en_w, up_w;
    logic [3:0] lv_w, cnt_w;
    logic       term_w, wr_w, ov_w;
    logic       rst_s, clr_s, ld_s, en_s, up_s;
    logic [3:0] lv_s, cnt_s;
    logic       term_s, wr_s, ov_s;
    logic       rst_f, clr_f, ld_f, en_f, up_f;
    logic [3:0] lv_f, cnt_f;
    logic       term_f, wr_f, ov_f;

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_w (
        .clock_reset ({rst_w, clk}), .clear (clr_w), .load (ld_w), .load_value (lv_w),
        .enable (en_w), .up (up_w), .count (cnt_w), .terminal (term_w),
        .wrapped (wr_w), .overflow (ov_w)
    );
    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(3)) u_s (
        .clock_reset ({rst_s, clk}), .clear (clr_s), .load (ld_s), .load_value (lv_s),
        .enable (en_s), .up (up_s), .count (cnt_s), .terminal (term_s),
        .wrapped (wr_s), .overflow (ov_s)
    );
    updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VALUE(0)) u_f (
        .clock_reset ({rst_f, clk}), .clear (clr_f), .load (ld_f), .load_value (lv_f),
        .enable (en_f), .up (up_f), .count (cnt_f), .terminal (term_f),
        .wrapped (wr_f), .overflow (ov_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input int c, input bit t, input bit w, input bit o);
        check({tag, ".count"}, 32'(cnt_w), 32'(c));
        check({tag, ".terminal"}, 32'(term_w), 32'(t));
        check({tag, ".wrapped"}, 32'(wr_w), 32'(w));
        check({tag, ".overflow"}, 32'(ov_w), 32'(o));
    endtask

    task automatic chk_s(input string tag, input int c, input bit t, input bit w, input bit o);
        check({tag, ".count"}, 32'(cnt_s), 32'(c));
        check({tag, ".terminal"}, 32'(term_s), 32'(t));
        check({tag, ".wrapped"}, 32'(wr_s), 32'(w));
        check({tag, ".overflow"}, 32'(ov_s), 32'(o));
    endtask

    task automatic chk_f(input string tag, input int c, input bit t, input bit w, input bit o);
        check({tag, ".count"}, 32'(cnt_f), 32'(c));
        check({tag, ".terminal"}, 32'(term_f), 32'(t));
        check({tag, ".wrapped"}, 32'(wr_f), 32'(w));
        check({tag, ".overflow"}, 32'(ov_f), 32'(o));
    endtask

    task automatic set_w(input bit c, input bit l, input logic [3:0] v, input bit e, input bit u);
        clr_w = c; ld_w = l; lv_w = v; en_w = e; up_w = u;
    endtask

    task automatic set_s(input bit c, input bit l, input logic [3:0] v, input bit e, input bit u);
        clr_s = c; ld_s = l; lv_s = v; en_s = e; up_s = u;
    endtask

    task automatic set_f(input bit c, input bit l, input logic [3:0] v, input bit e, input bit u);
        clr_f = c; ld_f = l; lv_f = v; en_f = e; up_f = u;
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  t1_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    bit  t1_term[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    bit  t1_wr  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit  t1_ov  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        rst_w = 1'b0; rst_s = 1'b0; rst_f = 1'b0;
        set_w(0, 0, 4'h0, 0, 0);
        set_s(0, 0, 4'h0, 0, 0);
        set_f(0, 0, 4'h0, 0, 0);
        #1;
        rst_w = 1'b1; rst_s = 1'b1; rst_f = 1'b1;
        #2;
        chk_w("reset_w", 0, 0, 0, 0);
        chk_s("reset_s", 3, 0, 0, 0);
        chk_f("reset_f", 0, 0, 0, 0);
        #4;
        rst_w = 1'b0; rst_s = 1'b0; rst_f = 1'b0;

        // Wrap mode counting up through the top of range
        set_w(0, 0, 4'h0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_w($sformatf("up_wrap[%0d]", i), t1_cnt[i], t1_term[i], t1_wr[i], t1_ov[i]);
        end

        // Clear beats enable, then count down through zero
        set_w(1, 0, 4'h0, 1, 1);
        step();
        chk_w("clear_w", 0, 0, 0, 0);
        set_w(0, 0, 4'h0, 1, 0);
        step();
        chk_w("down_wrap0", 9, 0, 1, 1);
        step();
        chk_w("down_wrap1", 8, 0, 0, 1);
        step();
        chk_w("down_wrap2", 7, 0, 0, 1);

        // Load clamp, load priority, clear priority, hold
        set_w(0, 1, 4'hC, 0, 1);
        step();
        chk_w("load_clamp", 9, 1, 0, 1);
        set_w(0, 1, 4'h5, 1, 1);
        step();
        chk_w("load_beats_en", 5, 0, 0, 1);
        set_w(1, 1, 4'h7, 1, 1);
        step();
        chk_w("clear_beats_load", 0, 0, 0, 0);
        set_w(0, 0, 4'h0, 0, 1);
        step();
        chk_w("hold_w", 0, 0, 0, 0);

        // Saturate mode at the top of range
        set_s(0, 1, 4'h9, 0, 1);
        step();
        chk_s("sat_load9", 9, 1, 0, 0);
        set_s(0, 0, 4'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_s($sformatf("sat_top[%0d]", i), 9, 1, 1, 1);
        end
        set_s(0, 0, 4'h0, 1, 0);
        step();
        chk_s("sat_down", 8, 0, 0, 1);

        // Saturate mode at zero
        set_s(0, 1, 4'h1, 0, 0);
        step();
        chk_s("sat_load1", 1, 0, 0, 1);
        set_s(0, 0, 4'h0, 1, 0);
        step();
        chk_s("sat_to0", 0, 1, 0, 1);
        step();
        chk_s("sat_bottom", 0, 1, 1, 1);

        // Asynchronous reset between edges at count 6
        set_s(0, 1, 4'h6, 0, 1);
        step();
        chk_s("pre_reset", 6, 0, 0, 1);
        set_s(0, 0, 4'h0, 1, 1);
        #2;
        rst_s = 1'b1;
        #1;
        chk_s("async_reset", 3, 0, 0, 0);
        step();
        chk_s("reset_held", 3, 0, 0, 0);
        #2;
        rst_s = 1'b0;
        #1;
        chk_s("reset_released", 3, 0, 0, 0);
        step();
        chk_s("first_after_reset", 4, 0, 0, 0);

        // Full-range modulus wraps in both directions
        set_f(0, 1, 4'hF, 0, 1);
        step();
        chk_f("full_load15", 15, 1, 0, 0);
        set_f(0, 0, 4'h0, 1, 1);
        step();
        chk_f("full_up_wrap", 0, 0, 1, 1);
        set_f(0, 0, 4'h0, 1, 0);
        step();
        chk_f("full_down_wrap", 15, 0, 1, 1);
        step();
        chk_f("full_down", 14, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
